// File: rtl/shift_register.sv
// Parallel-in, serial-out shifter for the LED snake datapath: latches a word and presents it
// MSB-first, one bit per enable strobe, with a sticky done flag and an exposed bit counter.
module shift_register #(
    parameter int W = 24,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [W-1:0]  in,
    input  logic          en,
    output logic          out,
    output logic          done,
    output logic [CW-1:0] bits_shifted_dbg
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    logic [W-1:0]  sreg_r;
    logic [W-1:0]  sreg_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          out_r;
    logic          out_s;
    logic          done_r;
    logic          done_s;

    // Next-state selection: the counter alone encodes ready (0), shifting (1..W-1) and closing (W).
    always_comb begin
        sreg_s = sreg_r;
        cnt_s  = cnt_r;
        out_s  = out_r;
        done_s = done_r;
        if (en) begin
            if (cnt_r == CNT_ZERO) begin
                out_s  = in[W-1];
                sreg_s = {in[W-2:0], 1'b0};
                cnt_s  = CNT_ONE;
                done_s = 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                out_s  = 1'b0;
                cnt_s  = CNT_ZERO;
                done_s = 1'b1;
            end else begin
                out_s  = sreg_r[W-1];
                sreg_s = {sreg_r[W-2:0], 1'b0};
                cnt_s  = cnt_r + CNT_ONE;
            end
        end else begin
            sreg_s = sreg_r;
            cnt_s  = cnt_r;
        end
    end

    // State registers; reset clears the word in flight immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg_r <= {W{1'b0}};
            cnt_r  <= CNT_ZERO;
            out_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            sreg_r <= sreg_s;
            cnt_r  <= cnt_s;
            out_r  <= out_s;
            done_r <= done_s;
        end
    end

    assign out              = out_r;
    assign done             = done_r;
    assign bits_shifted_dbg = cnt_r;

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register (W=24): word streaming, holds, mid-word
// input changes, asynchronous reset mid-word and sparse strobing.
module tb_shift_register;

    localparam int W  = 24;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rstn;
    logic [W-1:0]  in;
    logic          en;
    logic          out;
    logic          done;
    logic [CW-1:0] bits_shifted_dbg;

    int n_assert;
    int n_fail;

    shift_register #(.W(W)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .in               (in),
        .en               (en),
        .out              (out),
        .done             (done),
        .bits_shifted_dbg (bits_shifted_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_out, input int e_dbg, input logic e_done);
        chk({tag, ".out"},  {31'd0, out},  {31'd0, e_out});
        chk({tag, ".dbg"},  {{(32-CW){1'b0}}, bits_shifted_dbg}, 32'(e_dbg));
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    // Apply en for one clock cycle; inputs change and outputs are sampled on falling edges.
    task automatic cyc(input logic e);
        en = e;
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] word;
        n_assert = 0;
        n_fail   = 0;
        rstn = 1'b0;
        en   = 1'b1;
        in   = 24'hCA6FAE;

        // Reset held two cycles with en high: nothing moves.
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 0, 1'b0);
        rstn = 1'b1;

        // Word CA6FAE with en held high.
        word = 24'hCA6FAE;
        for (int i = 0; i < W; i++) begin
            cyc(1'b1);
            chk_all($sformatf("w1_s%0d", i + 1), word[W-1-i], i + 1, 1'b0);
        end
        in = 24'hFE0981;
        cyc(1'b0);
        chk_all("w1_hold_before_finish", 1'b0, 24, 1'b0);
        cyc(1'b1);
        chk_all("w1_finish", 1'b0, 0, 1'b1);
        cyc(1'b0);
        chk_all("w1_done_sticky", 1'b0, 0, 1'b1);

        // Word FE0981: single pulse, three idle cycles, then the rest.
        word = 24'hFE0981;
        cyc(1'b1);
        chk_all("w2_load", 1'b1, 1, 1'b0);
        in = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk_all($sformatf("w2_hold%0d", i), 1'b1, 1, 1'b0);
        end
        for (int i = 1; i < W; i++) begin
            cyc(1'b1);
            chk_all($sformatf("w2_s%0d", i + 1), word[W-1-i], i + 1, 1'b0);
        end
        cyc(1'b1);
        chk_all("w2_finish", 1'b0, 0, 1'b1);

        // Back-to-back: done lasts exactly one cycle; input changed after 5 strobes.
        word = 24'h5A3C96;
        in   = word;
        for (int i = 0; i < W; i++) begin
            if (i == 5) in = 24'hA5C369;
            cyc(1'b1);
            chk_all($sformatf("w3_s%0d", i + 1), word[W-1-i], i + 1, 1'b0);
        end
        cyc(1'b1);
        chk_all("w3_finish", 1'b0, 0, 1'b1);

        // Asynchronous reset after 10 strobes of A5F00F (bit 14 is 1).
        word = 24'hA5F00F;
        in   = word;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        chk_all("w4_dbg10", word[W-10], 10, 1'b0);
        en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk_all("reset_en_ignored", 1'b0, 0, 1'b0);
        in   = 24'h800001;
        rstn = 1'b1;

        // Sparse strobing: one strobe every three cycles over word 800001.
        word = 24'h800001;
        for (int i = 0; i < W; i++) begin
            cyc(1'b1);
            chk_all($sformatf("sp_s%0d", i + 1), word[W-1-i], i + 1, 1'b0);
            cyc(1'b0);
            cyc(1'b0);
            chk_all($sformatf("sp_h%0d", i + 1), word[W-1-i], i + 1, 1'b0);
        end
        cyc(1'b1);
        chk_all("sp_finish", 1'b0, 0, 1'b1);
        cyc(1'b0);
        chk_all("sp_done_sticky", 1'b0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
